eth_link_qualifier: RTL

ETH_LINK_QUALIFIER -- requirements
Module: eth_link_qualifier

---
 rtl/eth_link_qualifier.sv | 119 +++++++++++
 1 files changed

// File: rtl/eth_link_qualifier.sv
// Debounces the raw RXC link indication into a qualified LINK_OK with change pulse.
// Optional drop counter built only when ETH_LINK_DROP_CNT_EN is defined.
module eth_link_qualifier #(
  parameter int unsigned UP_CYCLES   = 4096,
  parameter int unsigned DOWN_CYCLES = 64
) (
  input  logic        clk200,
  input  logic        rst_n,
  input  logic        link_raw,
  input  logic        drops_clr,
  output logic        LINK_OK,
  output logic        LINK_EVT,
  output logic [1:0]  LINK_STATE,
  output logic [15:0] LINK_DROPS
);

  typedef enum logic [1:0] {
    ST_DOWN      = 2'd0,
    ST_QUAL_UP   = 2'd1,
    ST_UP        = 2'd2,
    ST_QUAL_DOWN = 2'd3
  } state_t;

  localparam logic [15:0] UP_LAST   = 16'(UP_CYCLES - 1);
  localparam logic [15:0] DOWN_LAST = 16'(DOWN_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_timer;
  logic        r_link_q;
  logic        r_ok;
  logic        r_evt;

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_DOWN;
      r_timer  <= '0;
      r_link_q <= 1'b0;
      r_ok     <= 1'b0;
      r_evt    <= 1'b0;
    end else begin
      r_link_q <= link_raw;
      // NOTE: r_evt defaults low here and is overridden below; the last non-blocking write wins, giving a one-cycle pulse.
      r_evt    <= 1'b0;
      case (r_state)
        ST_DOWN: begin
          if (r_link_q) begin
            r_state <= ST_QUAL_UP;
            r_timer <= '0;
          end
        end
        ST_QUAL_UP: begin
          if (!r_link_q) begin
            r_state <= ST_DOWN;
            r_timer <= '0;
          end else if (r_timer == UP_LAST) begin
            r_state <= ST_UP;
            r_timer <= '0;
            r_ok    <= 1'b1;
            r_evt   <= 1'b1;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        ST_UP: begin
          if (!r_link_q) begin
            r_state <= ST_QUAL_DOWN;
            r_timer <= '0;
          end
        end
        ST_QUAL_DOWN: begin
          if (r_link_q) begin
            r_state <= ST_UP;
            r_timer <= '0;
          end else if (r_timer == DOWN_LAST) begin
            r_state <= ST_DOWN;
            r_timer <= '0;
            r_ok    <= 1'b0;
            r_evt   <= 1'b1;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: begin
          r_state <= ST_DOWN;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign LINK_OK    = r_ok;
  assign LINK_EVT   = r_evt;
  assign LINK_STATE = r_state;

`ifdef ETH_LINK_DROP_CNT_EN
  logic [15:0] r_drops;
  logic        w_drop;

  // A drop is the confirmed QUAL_DOWN -> DOWN step, not an aborted qualification.
  assign w_drop = (r_state == ST_QUAL_DOWN) && !r_link_q && (r_timer == DOWN_LAST);

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      r_drops <= '0;
    end else if (drops_clr) begin
      r_drops <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_drops != 16'hFFFF)) begin
      r_drops <= r_drops + 16'd1;
    end
  end

  assign LINK_DROPS = r_drops;
`else
  logic w_unused_drops_clr;
  assign w_unused_drops_clr = drops_clr;
  assign LINK_DROPS         = 16'h0000;
`endif

endmodule
